qerv_bufreg4: RTL and testbench
===============================

// Module: qerv_bufreg4
// PURPOSE
//  Nibble-serial buffer register directly downstream of the immediate decoder. Each cycle it adds
//  one W-bit lane of rs1 and one lane of the decoded immediate, carrying between lanes, and shifts
//  the sum into a 32-bit register. After XLEN/W cycles it holds the load/store/jump target
//  (rs1+imm). It also captures data-bus load data and rotates it back out serially for writeback.
// PARAMETERS
//  W     4   lane width per cycle; legal values 1, 2, 4
//  XLEN  32  register width; fixed at 32
//  (localparam CNT_W = $clog2(XLEN/W), the lane-counter width)
// PORTS
//  i_clk        in   1      clock
//  i_rst_n      in   1      asynchronous reset, active low
//  i_cnt_en     in   1      advance one lane: add/rotate and shift
//  i_rs1_en     in   1      include i_rs1 in the sum
//  i_imm_en     in   1      include i_imm in the sum
//  i_clr_lsb    in   1      force bit 0 of the lane-0 sum to 0 (JALR)
//  i_rot        in   1      rotate mode: shift d[W-1:0] back in; adder bypassed
//  i_rs1        in   W      rs1 lane, LSB lane first
//  i_imm        in   W      immediate lane from immdec o_imm
//  i_load       in   1      capture i_dbus_rdt when i_dbus_ack is high
//  i_dbus_ack   in   1      data-bus acknowledge
//  i_dbus_rdt   in   32     data-bus read data
//  o_q          out  W      current output lane, d[W-1:0]
//  o_dbus_adr   out  32     {d[31:2],2'b00}
//  o_lsb        out  2      byte offset captured from lane 0
//  o_last       out  1      high while the counter is at its final lane (XLEN/W-1)
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   d=0, carry=0, cnt=0, lsb=0. Outputs: o_q=0, o_dbus_adr=0, o_lsb=0, o_last=0.
//  Lane step (i_cnt_en=1, no load capture):
//   a   = i_rs1_en ? i_rs1 : 0
//   b   = i_imm_en ? i_imm : 0
//   cin = (cnt==0) ? 0 : carry
//   sum = a + b + cin, W+1 bits wide
//   if cnt==0 and i_clr_lsb: sum[0] forced to 0
//   i_rot=1: lane = d[W-1:0]; carry unchanged
//   else:    lane = sum[W-1:0]; carry <= sum[W]
//   d <= {lane, d[31:W]}; cnt <= cnt+1, wrapping from last lane to 0
//   if cnt==0 and !i_rot: lsb <= sum[1:0] (after clr; for W=1, lsb[1] is taken at cnt==1)
//  Carry-out of the final lane is discarded; the sum is modulo 2^32.
//  Load capture (i_load & i_dbus_ack): d <= i_dbus_rdt. Carry, cnt and lsb are unchanged.
//  Simultaneous capture and i_cnt_en: capture wins; no shift; cnt holds.
//  i_load without i_dbus_ack: no effect. Handshake waits are unbounded.
//  o_last is combinational from cnt and i_cnt_en: o_last = i_cnt_en & (cnt==XLEN/W-1).
//  Latency: the address is valid on o_dbus_adr the cycle after the final lane. Read data is
//   valid on o_q the cycle after capture; rotating for XLEN/W cycles returns d to its original value.
//  i_cnt_en low: all state holds.
//  Reset asserted mid-sequence: immediate clear; the next sequence starts at lane 0.
// STRUCTURE
//  Constants (XLEN, legal W set) go in the shared qerv_pkg header.
//  One natural sub-module: qerv_lane_add (W-bit adder, carry in/out, lane-0 clr).
//  Everything else is flat: shift register, counter, lsb capture.
//  Target size: about 150-250 lines.
// TESTING
//  1. W=4, rs1=0x0000_1000, imm=0x0000_0FFC, both enabled, 8 lanes
//     -> o_dbus_adr=0x0000_1FFC, o_lsb=0, o_last high in cycle 8 only.
//  2. rs1=0x0000_00FF, imm=0x0000_0001 -> carry ripples through two lanes
//     -> d=0x0000_0100.
//  3. rs1=0xFFFF_FFFF, imm=1 -> d=0 (wrap; final carry dropped).
//     Same with i_clr_lsb, rs1=0x8003, imm=0 -> d=0x8002, o_lsb=2'b10.
//  4. i_load with ack, rdt=0xDEAD_BEEF, then 8 cycles of i_rot
//     -> o_q emits F,E,E,B,D,A,E,D; d returns to 0xDEAD_BEEF.
//  5. i_load and i_cnt_en in the same cycle -> d=rdt, cnt unchanged.
//     i_load with no ack for 5 cycles -> d unchanged.
//  6. Reset after lane 3 of a sum -> all outputs 0 while reset is held.
//     A fresh sum rs1=5, imm=7 -> d=0xC, with no stale carry.
//  Repeat scenarios 1-3 with W=1 and W=2.

Source files
------------

// File: rtl/qerv_pkg.sv
// Shared constants for the nibble-serial qerv datapath blocks.
package qerv_pkg;
  localparam int XLEN = 32;

  // Number of W-wide lanes in one XLEN word (W in {1,2,4}).
  function automatic int lanes(input int w);
    return XLEN / w;
  endfunction
endpackage

// File: rtl/qerv_lane_add.sv
// One lane of the serial rs1+imm adder: W-bit add with carry in/out and an
// optional clear of the result LSB (JALR target alignment).
module qerv_lane_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_clr,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W:0] s;

  // The clear only touches the result bit; the carry comes from the true sum.
  always_comb begin
    s = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    if (i_clr) s[0] = 1'b0;
  end

  assign o_sum  = s[W-1:0];
  assign o_cout = s[W];
endmodule

// File: rtl/qerv_bufreg4.sv
// Lane-serial buffer register: accumulates rs1+imm into a 32-bit shift register,
// captures load data from the data bus and rotates it back out lane by lane.
module qerv_bufreg4
  import qerv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cnt_en,
  input  logic            i_rs1_en,
  input  logic            i_imm_en,
  input  logic            i_clr_lsb,
  input  logic            i_rot,
  input  logic [W-1:0]    i_rs1,
  input  logic [W-1:0]    i_imm,
  input  logic            i_load,
  input  logic            i_dbus_ack,
  input  logic [XLEN-1:0] i_dbus_rdt,
  output logic [W-1:0]    o_q,
  output logic [XLEN-1:0] o_dbus_adr,
  output logic [1:0]      o_lsb,
  output logic            o_last
);
  localparam int NLANE = lanes(W);
  localparam int CNT_W = $clog2(NLANE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NLANE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [XLEN-1:0]  d_q, d_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lsb_q, lsb_d;

  logic             lane0;
  logic             capture;
  logic [W-1:0]     op_a, op_b;
  logic [W-1:0]     sum;
  logic             cout;
  logic [1:0]       sum_lo;
  logic [W-1:0]     lane;

  assign lane0   = (cnt_q == '0);
  assign capture = i_load & i_dbus_ack;
  assign op_a    = i_rs1_en ? i_rs1 : '0;
  assign op_b    = i_imm_en ? i_imm : '0;
  // Zero-extends for W=1 so the low-two-bit view is always legal.
  assign sum_lo  = 2'(sum);
  assign lane    = i_rot ? d_q[W-1:0] : sum;

  qerv_lane_add #(.W(W)) u_add (
    .i_a    (op_a),
    .i_b    (op_b),
    .i_cin  (lane0 ? 1'b0 : carry_q),
    .i_clr  (lane0 & i_clr_lsb),
    .o_sum  (sum),
    .o_cout (cout)
  );

  always_comb begin
    d_d     = d_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
    if (capture) begin
      d_d = i_dbus_rdt;
    end else if (i_cnt_en) begin
      d_d   = {lane, d_q[XLEN-1:W]};
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      if (!i_rot) begin
        carry_d = cout;
        // With single-bit lanes the byte offset spans the first two lanes.
        if (W == 1) begin
          if (lane0)                 lsb_d[0] = sum_lo[0];
          else if (cnt_q == CNT_ONE) lsb_d[1] = sum_lo[0];
        end else if (lane0) begin
          lsb_d = sum_lo;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      lsb_q   <= 2'b00;
    end else begin
      d_q     <= d_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
    end
  end

  assign o_q        = d_q[W-1:0];
  assign o_dbus_adr = {d_q[XLEN-1:2], 2'b00};
  assign o_lsb      = lsb_q;
  assign o_last     = i_cnt_en & (cnt_q == CNT_LAST);
endmodule

// File: tb/tb_qerv_bufreg4.sv
// Bench for qerv_bufreg4: three instances (W=1,2,4) checked against a word-level
// model of rs1+imm, load capture and rotation.
module tb_qerv_bufreg4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en = '0;
  logic [2:0]  ld = '0;
  logic        rs1_en = 1'b0, imm_en = 1'b0, clr = 1'b0, rot = 1'b0, ack = 1'b0;
  logic [31:0] rdt = '0;
  logic [3:0]  rs1_4 = '0, imm_4 = '0;
  logic [1:0]  rs1_2 = '0, imm_2 = '0;
  logic        rs1_1 = 1'b0, imm_1 = 1'b0;

  logic [3:0]  q4;
  logic [1:0]  q2;
  logic        q1;
  logic [31:0] adr4, adr2, adr1;
  logic [1:0]  lsb4, lsb2, lsb1;
  logic        last4, last2, last1;

  int          total = 0;
  int          bad = 0;
  logic [31:0] d_m [3];
  logic [1:0]  lsb_m [3];

  always #5 clk = ~clk;

  qerv_bufreg4 #(.W(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt_en(en[0]), .i_rs1_en(rs1_en), .i_imm_en(imm_en),
    .i_clr_lsb(clr), .i_rot(rot), .i_rs1(rs1_1), .i_imm(imm_1), .i_load(ld[0]),
    .i_dbus_ack(ack), .i_dbus_rdt(rdt), .o_q(q1), .o_dbus_adr(adr1), .o_lsb(lsb1), .o_last(last1));
  qerv_bufreg4 #(.W(2)) u_w2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt_en(en[1]), .i_rs1_en(rs1_en), .i_imm_en(imm_en),
    .i_clr_lsb(clr), .i_rot(rot), .i_rs1(rs1_2), .i_imm(imm_2), .i_load(ld[1]),
    .i_dbus_ack(ack), .i_dbus_rdt(rdt), .o_q(q2), .o_dbus_adr(adr2), .o_lsb(lsb2), .o_last(last2));
  qerv_bufreg4 #(.W(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt_en(en[2]), .i_rs1_en(rs1_en), .i_imm_en(imm_en),
    .i_clr_lsb(clr), .i_rot(rot), .i_rs1(rs1_4), .i_imm(imm_4), .i_load(ld[2]),
    .i_dbus_ack(ack), .i_dbus_rdt(rdt), .o_q(q4), .o_dbus_adr(adr4), .o_lsb(lsb4), .o_last(last4));

  function automatic int wof(input int wi);
    return 1 << wi;
  endfunction

  function automatic logic [31:0] obs_q(input int wi);
    case (wi)
      0:       return {31'b0, q1};
      1:       return {30'b0, q2};
      default: return {28'b0, q4};
    endcase
  endfunction

  function automatic logic [31:0] obs_adr(input int wi);
    case (wi)
      0:       return adr1;
      1:       return adr2;
      default: return adr4;
    endcase
  endfunction

  function automatic logic [31:0] obs_lsb(input int wi);
    case (wi)
      0:       return {30'b0, lsb1};
      1:       return {30'b0, lsb2};
      default: return {30'b0, lsb4};
    endcase
  endfunction

  function automatic logic [31:0] obs_last(input int wi);
    case (wi)
      0:       return {31'b0, last1};
      1:       return {31'b0, last2};
      default: return {31'b0, last4};
    endcase
  endfunction

  // Word rotated right by n bits, low w bits returned.
  function automatic logic [31:0] rot_lane(input logic [31:0] v, input int n, input int w);
    logic [63:0] dbl;
    logic [31:0] r;
    dbl = {v, v} >> n;
    r   = dbl[31:0];
    return r & ((32'h1 << w) - 32'h1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic chk_state(input int wi, input string tag);
    int w;
    w = wof(wi);
    chk({tag, "_adr"}, obs_adr(wi), {d_m[wi][31:2], 2'b00});
    chk({tag, "_q"},   obs_q(wi),   rot_lane(d_m[wi], 0, w));
    chk({tag, "_lsb"}, obs_lsb(wi), {30'b0, lsb_m[wi]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sum(input int wi, input logic [31:0] a, input logic [31:0] b,
                         input bit ae, input bit be, input bit c, input string tag);
    int w, nl;
    logic [31:0] e;
    w = wof(wi);
    nl = 32 / w;
    rs1_en = ae; imm_en = be; clr = c; rot = 1'b0;
    for (int i = 0; i < nl; i++) begin
      rs1_4 = 4'(a >> (i * 4)); imm_4 = 4'(b >> (i * 4));
      rs1_2 = 2'(a >> (i * 2)); imm_2 = 2'(b >> (i * 2));
      rs1_1 = 1'(a >> i);       imm_1 = 1'(b >> i);
      en = 3'(1 << wi);
      #1;
      chk($sformatf("%s_last%0d", tag, i), obs_last(wi), (i == nl - 1) ? 32'd1 : 32'd0);
      step();
    end
    en = '0; clr = 1'b0;
    e = (ae ? a : 32'd0) + (be ? b : 32'd0);
    if (c) e = e & ~32'd1;
    d_m[wi] = e;
    lsb_m[wi] = e[1:0];
    chk_state(wi, tag);
  endtask

  task automatic do_load(input int wi, input logic [31:0] v, input bit with_en, input string tag);
    ld = 3'(1 << wi); ack = 1'b1; rdt = v; rot = 1'b0;
    en = with_en ? 3'(1 << wi) : 3'b0;
    step();
    ld = '0; ack = 1'b0; en = '0;
    d_m[wi] = v;
    chk_state(wi, tag);
  endtask

  task automatic do_rot(input int wi, input string tag);
    int w, nl;
    w = wof(wi);
    nl = 32 / w;
    rot = 1'b1; rs1_en = 1'b0; imm_en = 1'b0;
    chk($sformatf("%s_q0", tag), obs_q(wi), rot_lane(d_m[wi], 0, w));
    for (int k = 1; k <= nl; k++) begin
      en = 3'(1 << wi);
      step();
      chk($sformatf("%s_q%0d", tag, k), obs_q(wi), rot_lane(d_m[wi], k * w, w));
    end
    en = '0; rot = 1'b0;
    chk_state(wi, {tag, "_back"});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_m[i] = '0;
      lsb_m[i] = '0;
    end
    en = 3'b111;
    #2;
    for (int wi = 0; wi < 3; wi++) begin
      chk_state(wi, $sformatf("rst_w%0d", wof(wi)));
      chk($sformatf("rst_last_w%0d", wof(wi)), obs_last(wi), 32'd0);
    end
    en = '0;
    #5 rst_n = 1'b1;
    step();

    for (int wi = 2; wi >= 0; wi--) begin
      run_sum(wi, 32'h0000_1000, 32'h0000_0FFC, 1, 1, 0, "t1");
      run_sum(wi, 32'h0000_00FF, 32'h0000_0001, 1, 1, 0, "t2");
      run_sum(wi, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, "t3wrap");
      run_sum(wi, 32'h0000_8003, 32'h0000_0000, 1, 1, 1, "t3clr");
    end

    do_load(2, 32'hDEAD_BEEF, 0, "t4ld");
    do_rot(2, "t4rot");
    do_load(1, 32'hDEAD_BEEF, 0, "t4ld_w2");
    do_rot(1, "t4rot_w2");

    do_load(2, 32'h1234_5678, 1, "t5ld_en");
    run_sum(2, 32'h0000_1000, 32'h0000_0FFC, 1, 1, 0, "t5after");
    ld = 3'b100; ack = 1'b0; rdt = 32'hA5A5_5A5A;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_state(2, $sformatf("t5noack%0d", i));
    end
    ld = '0;

    rs1_en = 1'b1; imm_en = 1'b1; rot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs1_4 = 4'hF; imm_4 = (i == 0) ? 4'h1 : 4'h0;
      en = 3'b100;
      step();
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      d_m[i] = '0;
      lsb_m[i] = '0;
    end
    chk_state(2, "t6rst");
    chk("t6rst_last", obs_last(2), 32'd0);
    en = '0;
    step();
    chk_state(2, "t6held");
    rst_n = 1'b1;
    step();
    run_sum(2, 32'd5, 32'd7, 1, 1, 0, "t6fresh");
    run_sum(0, 32'd5, 32'd7, 1, 1, 0, "t6fresh_w1");

    for (int wi = 0; wi < 3; wi++) begin
      for (int n = 0; n < 12; n++) begin
        case ($urandom_range(2, 0))
          0: run_sum(wi, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                     $sformatf("rnd_sum_w%0d_%0d", wof(wi), n));
          1: begin
            do_load(wi, $urandom, 1'($urandom), $sformatf("rnd_ld_w%0d_%0d", wof(wi), n));
            do_rot(wi, $sformatf("rnd_rot_w%0d_%0d", wof(wi), n));
          end
          default: begin
            rs1_en = 1'b1; imm_en = 1'b1; rs1_4 = 4'($urandom); imm_4 = 4'($urandom);
            for (int k = 0; k < 3; k++) step();
            chk_state(wi, $sformatf("rnd_idle_w%0d_%0d", wof(wi), n));
          end
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
